// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer and datapath muxes.
// Latency: n/a (constants only). Backpressure: n/a.
// State codes, opcodes, mux select encodings and the control vector layout.
package ctrl_pkg;

    typedef enum logic [6:0] {
        S_FETCH    = 7'd0,
        S_DECODE   = 7'd1,
        S_MEMADDR  = 7'd2,
        S_MEMREAD  = 7'd3,
        S_MEMWB    = 7'd4,
        S_MEMWRITE = 7'd5,
        S_REXEC    = 7'd6,
        S_RWB      = 7'd7,
        S_BRANCH   = 7'd8,
        S_JUMP     = 7'd9,
        S_ADDIEXEC = 7'd10,
        S_ADDIWB   = 7'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational decode of current state (plus mem_ready) into the control vector.
// Latency: 0 cycles. Backpressure: mem_ready gates the FETCH ir/pc load strobes only.
// en=0 forces the whole vector to zero.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  logic   en,
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        if (en) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH;
                end
                S_MEMADDR, S_ADDIEXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                end
                S_MEMREAD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEMWRITE: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                S_REXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_B;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                S_RWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_B;
                    ctrl.alu_op        = ALU_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
                S_ADDIWB: begin
                    ctrl.reg_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle datapath control sequencer: 7-bit state register, opcode decode, output decode.
// Latency: outputs are combinational from state; one state transition per clk edge.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold until mem_ready; other states ignore it.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [6:0] state,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op
);

    state_t state_q, state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_RTYPE:     state_d = S_REXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADDR: begin
                if (opcode == OP_LW)      state_d = S_MEMREAD;
                else if (opcode == OP_SW) state_d = S_MEMWRITE;
                else                      state_d = S_FETCH;
            end
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_REXEC:    state_d = S_RWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            // MEMWB, RWB, BRANCH, JUMP, ADDIWB and all illegal codes return to FETCH
            default:    state_d = S_FETCH;
        endcase
    end

    ctrl_out_decode u_decode (
        .en        (reset),
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign state         = reset ? state_q : 7'd0;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = reset && (state_q == S_DECODE) && !op_legal(opcode);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed vector table plus randomized instruction stream against a route-based model.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [6:0] state;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .state(state), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op)
    );

    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
    function automatic logic [16:0] mk(input logic pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, sa,
                                       input logic [1:0] sb, aop, ps, input logic ill);
        return {pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, ill};
    endfunction

    wire [16:0] dut_vec = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                           pc_source, illegal_op};

    logic [16:0] E_ZERO, E_FR, E_FW, E_DEC, E_DECI, E_MA, E_MRD, E_MWB, E_MW;
    logic [16:0] E_REX, E_RWB, E_BR, E_JMP, E_AEX, E_AWB;

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    endfunction

    function automatic logic [16:0] exp_ctrl(input int st, input logic rdy, input logic [5:0] op);
        case (st)
            0:  return rdy ? E_FR : E_FW;
            1:  return is_legal(op) ? E_DEC : E_DECI;
            2:  return E_MA;
            3:  return E_MRD;
            4:  return E_MWB;
            5:  return E_MW;
            6:  return E_REX;
            7:  return E_RWB;
            8:  return E_BR;
            9:  return E_JMP;
            10: return E_AEX;
            11: return E_AWB;
            default: return E_ZERO;
        endcase
    endfunction

    task automatic compare(input string name, input logic [6:0] exp_st, input logic [16:0] exp_c);
        checks++;
        if (state !== exp_st) begin
            failures++;
            $display("FAIL %s state: got %0d want %0d @%0t", name, state, exp_st, $time);
        end
        checks++;
        if (dut_vec !== exp_c) begin
            failures++;
            $display("FAIL %s ctrl: got %b want %b (state %0d) @%0t", name, dut_vec, exp_c, state, $time);
        end
        checks++;
        if (mem_read && mem_write) begin
            failures++;
            $display("FAIL %s rd_wr_excl: got mem_read=1 mem_write=1 want not both @%0t", name, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [6:0]  st;
        logic [16:0] ctl;
        string       name;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                       input logic [6:0] st, input logic [16:0] ctl, input string name);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl; v.name = name;
        tbl.push_back(v);
    endtask

    // Instruction route as the sequence of state codes it visits.
    function automatic void make_route(input logic [5:0] op, output int r[$]);
        r = {0, 1};
        case (op)
            6'h23: r = {0, 1, 2, 3, 4};
            6'h2B: r = {0, 1, 2, 5};
            6'h00: r = {0, 1, 6, 7};
            6'h08: r = {0, 1, 10, 11};
            6'h04: r = {0, 1, 8};
            6'h02: r = {0, 1, 9};
            default: r = {0, 1};
        endcase
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] ops [9];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h01, 6'h10};
        return ops[$urandom_range(0, 8)];
    endfunction

    initial begin
        int route[$];
        int idx;
        int cyc_lw;
        logic [5:0] cur_op;

        E_ZERO = '0;
        E_FR   = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
        E_FW   = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
        E_DEC  = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
        E_DECI = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
        E_MA   = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        E_MRD  = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        E_MWB  = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
        E_MW   = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        E_REX  = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
        E_RWB  = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
        E_BR   = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
        E_JMP  = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
        E_AEX  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        E_AWB  = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);

        add(0, 6'h23, 1, 0, E_ZERO, "reset0");
        add(0, 6'h23, 1, 0, E_ZERO, "reset1");
        add(1, 6'h23, 1, 0, E_FR,   "lw_fetch");
        add(1, 6'h23, 1, 1, E_DEC,  "lw_decode");
        add(1, 6'h23, 1, 2, E_MA,   "lw_memaddr");
        add(1, 6'h23, 1, 3, E_MRD,  "lw_memread");
        add(1, 6'h23, 1, 4, E_MWB,  "lw_memwb");
        add(1, 6'h2B, 1, 0, E_FR,   "sw_fetch");
        add(1, 6'h2B, 0, 1, E_DEC,  "sw_decode_rdy_ignored");
        add(1, 6'h2B, 0, 2, E_MA,   "sw_memaddr_rdy_ignored");
        add(1, 6'h2B, 0, 5, E_MW,   "sw_wait1");
        add(1, 6'h2B, 0, 5, E_MW,   "sw_wait2");
        add(1, 6'h2B, 0, 5, E_MW,   "sw_wait3");
        add(1, 6'h2B, 1, 5, E_MW,   "sw_done");
        add(1, 6'h04, 1, 0, E_FR,   "beq_fetch");
        add(1, 6'h04, 1, 1, E_DEC,  "beq_decode");
        add(1, 6'h04, 1, 8, E_BR,   "beq_branch");
        add(1, 6'h02, 1, 0, E_FR,   "j_fetch");
        add(1, 6'h02, 1, 1, E_DEC,  "j_decode");
        add(1, 6'h02, 1, 9, E_JMP,  "j_jump");
        add(1, 6'h3F, 0, 0, E_FW,   "ill_fetch_wait");
        add(1, 6'h3F, 1, 0, E_FR,   "ill_fetch");
        add(1, 6'h3F, 1, 1, E_DECI, "ill_decode");
        add(1, 6'h00, 1, 0, E_FR,   "r_abort_fetch");
        add(1, 6'h00, 1, 1, E_DEC,  "r_abort_decode");
        add(1, 6'h00, 1, 6, E_REX,  "r_abort_rexec");
        add(0, 6'h00, 1, 0, E_ZERO, "r_abort_rwb_reset");
        add(1, 6'h00, 1, 0, E_FR,   "r_fetch");
        add(1, 6'h00, 1, 1, E_DEC,  "r_decode");
        add(1, 6'h00, 1, 6, E_REX,  "r_rexec");
        add(1, 6'h00, 1, 7, E_RWB,  "r_rwb");
        add(1, 6'h08, 1, 0, E_FR,   "addi_fetch");
        add(1, 6'h08, 1, 1, E_DEC,  "addi_decode");
        add(1, 6'h08, 1, 10, E_AEX, "addi_exec");
        add(1, 6'h08, 1, 11, E_AWB, "addi_wb");
        add(1, 6'h23, 1, 0, E_FR,   "back_to_fetch");

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; opcode = tbl[i].op; mem_ready = tbl[i].rdy;
            #1;
            compare(tbl[i].name, tbl[i].st, tbl[i].ctl);
            @(posedge clk); #1;
        end

        // LW with two MEMREAD stalls: 5 base cycles + 2 stalled = 7 FETCH-to-FETCH.
        reset = 0; mem_ready = 1; opcode = 6'h23;
        @(posedge clk); #1;
        reset = 1; cyc_lw = 0;
        for (int c = 0; c < 20; c++) begin
            mem_ready = !(state == 7'd3 && c < 5);
            #1;
            if (c > 0 && state == 7'd0) break;
            cyc_lw++;
            @(posedge clk); #1;
        end
        checks++;
        if (cyc_lw != 7) begin
            failures++;
            $display("FAIL lw_stall_cycles: got %0d want 7", cyc_lw);
        end

        // Randomized instruction stream with occasional mid-instruction reset.
        reset = 0; mem_ready = 1;
        @(posedge clk); #1;
        reset = 1;
        cur_op = pick_op(); make_route(cur_op, route); idx = 0;
        for (int c = 0; c < 3000; c++) begin
            opcode    = cur_op;
            mem_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 149) != 0);
            #1;
            if (!reset) compare("rand_reset", 7'd0, E_ZERO);
            else        compare("rand", 7'(route[idx]), exp_ctrl(route[idx], mem_ready, cur_op));
            @(posedge clk); #1;
            if (!reset) begin
                cur_op = pick_op(); make_route(cur_op, route); idx = 0;
            end else if (!(route[idx] inside {0, 3, 5}) || mem_ready) begin
                idx++;
                if (idx == route.size()) begin
                    cur_op = pick_op(); make_route(cur_op, route); idx = 0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
